spi_readback_tx: RTL

- SPI slave transmit path for the Nexys4 display register file: the MISO-side counterpart of the display's SPI write receiver.
- Decodes a read command in the first byte of a 16-bit frame, then shifts the addressed 8-bit register out on MISO, MSB first, during the second byte.
- Sits beside the display receiver on the same SPI pins, so the host can read back the enable, digit and radix registers.

---
 rtl/spi_readback_tx.sv | 78 +++++++
 1 files changed

// File: rtl/spi_readback_tx.sv
// spi_readback_tx: SPI slave MISO path that decodes a read command byte and
// shifts the addressed display register out MSB first in the following byte.
// Ports:
//   rst_low_i    async active-low reset
//   spi_sclk_i   SPI clock (idle low, sample on posedge, drive on negedge)
//   spi_ss_i     slave select, active low; high aborts the frame asynchronously
//   spi_mosi_i   command bits from the master
//   reg_file_i   flattened register file, register n at [8n+7:8n]
//   spi_miso_o   read data to the master, idle high
//   rd_active_o  high during the data phase of a valid read
//   rd_addr_o    address field of the last command byte
//   read_count_o completed valid read frames, wrapping
module spi_readback_tx #(
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_REGISTERS = 10,
  parameter logic [3:0] READ_CMD = 4'b0010,
  parameter logic [BYTE_WIDTH-1:0] FILL_BYTE = 8'hFF
) (
  input  logic                                rst_low_i,
  input  logic                                spi_sclk_i,
  input  logic                                spi_ss_i,
  input  logic                                spi_mosi_i,
  input  logic [NUM_REGISTERS*BYTE_WIDTH-1:0] reg_file_i,
  output logic                                spi_miso_o,
  output logic                                rd_active_o,
  output logic [3:0]                          rd_addr_o,
  output logic [7:0]                          read_count_o
);
  logic [3:0] bit_cnt;
  logic [BYTE_WIDTH-2:0] cmd_sr;
  logic [BYTE_WIDTH-1:0] cmd, tx_sr, sel;
  logic read_valid;
  assign cmd = {cmd_sr, spi_mosi_i};
  assign spi_miso_o = spi_ss_i ? 1'b1 : tx_sr[BYTE_WIDTH-1];
  assign rd_active_o = read_valid & bit_cnt[3];
  // reg_file_i is quasi-static; it is only captured at the loading negedge
  always_comb begin
    sel = FILL_BYTE;
    for (int i = 0; i < NUM_REGISTERS; i++)
      if (rd_addr_o == 4'(i)) sel = reg_file_i[BYTE_WIDTH*i +: BYTE_WIDTH];
  end
  // bit_cnt wraps 15 -> 0 so back-to-back frames work under one ss low
  always_ff @(posedge spi_sclk_i or negedge rst_low_i or posedge spi_ss_i) begin
    if (!rst_low_i) begin
      bit_cnt <= '0;
      cmd_sr <= '0;
      read_valid <= 1'b0;
      rd_addr_o <= '0;
    end else if (spi_ss_i) begin
      bit_cnt <= '0;
      cmd_sr <= '0;
      read_valid <= 1'b0;
      rd_addr_o <= '0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
      if (!bit_cnt[3]) cmd_sr <= cmd[BYTE_WIDTH-2:0];
      if (bit_cnt == 4'd7) begin
        read_valid <= (cmd[BYTE_WIDTH-1 -: 4] == READ_CMD) && (32'(cmd[3:0]) < NUM_REGISTERS);
        rd_addr_o <= cmd[3:0];
      end else if (bit_cnt == 4'd15) begin
        read_valid <= 1'b0;
      end
    end
  end
  // the count survives frame aborts, so only reset clears it
  always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
    if (!rst_low_i) read_count_o <= '0;
    else if (!spi_ss_i && bit_cnt == 4'd15 && read_valid) read_count_o <= read_count_o + 8'd1;
  end
  // loading on the 8th negedge puts data bit 7 on MISO ahead of posedge 9
  always_ff @(negedge spi_sclk_i or negedge rst_low_i or posedge spi_ss_i) begin
    if (!rst_low_i) tx_sr <= '1;
    else if (spi_ss_i) tx_sr <= '1;
    else if (bit_cnt == 4'd8) tx_sr <= read_valid ? sel : FILL_BYTE;
    else if (bit_cnt[3]) tx_sr <= {tx_sr[BYTE_WIDTH-2:0], 1'b1};
    else tx_sr <= '1;
  end
endmodule
